// File: rtl/vga_cell_timing.sv
// 640x480@60 VGA timing generator with coarse cell coordinates.
// Pixel counters run off a clock-enable; all derived outputs lag them by one clk.
module vga_cell_timing #(
  parameter int   CLK_DIV    = 4,
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter int   CELL_SHIFT = 4,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [5:0] counter_x,
  output logic [5:0] counter_y,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_M1 = 4'(CLK_DIV - 1);
  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HT_M1  = 10'(H_TOTAL - 1);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VT_M1  = 10'(V_TOTAL - 1);

  logic [3:0] r_div;
  logic       r_pix_en;
  logic [9:0] r_pix_x;
  logic [9:0] r_pix_y;
  logic       r_wrap;
  logic       r_frame_tick;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic [5:0] r_cx;
  logic [5:0] r_cy;

  logic [3:0] w_div_nxt;
  logic       w_last_x;
  logic       w_last_y;
  logic       w_vid;
  logic       w_hs_act;
  logic       w_vs_act;
  logic [9:0] w_cx_full;
  logic [9:0] w_cy_full;

  assign w_div_nxt = (r_div == DIV_M1) ? 4'd0 : r_div + 4'd1;
  assign w_last_x  = (r_pix_x == HT_M1);
  assign w_last_y  = (r_pix_y == VT_M1);
  assign w_vid     = (r_pix_x < HA) && (r_pix_y < VA);
  assign w_hs_act  = (r_pix_x >= HS_LO) && (r_pix_x < HS_HI);
  assign w_vs_act  = (r_pix_y >= VS_LO) && (r_pix_y < VS_HI);
  assign w_cx_full = r_pix_x >> CELL_SHIFT;
  assign w_cy_full = r_pix_y >> CELL_SHIFT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div        <= '0;
      r_pix_en     <= 1'b0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_wrap       <= 1'b0;
      r_frame_tick <= 1'b0;
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
      r_video_on   <= 1'b0;
      r_cx         <= 6'd63;
      r_cy         <= 6'd63;
    end else begin
      r_div    <= w_div_nxt;
      r_pix_en <= (w_div_nxt == DIV_M1);
      if (r_pix_en) begin
        r_pix_x <= w_last_x ? 10'd0 : r_pix_x + 10'd1;
        if (w_last_x)
          r_pix_y <= w_last_y ? 10'd0 : r_pix_y + 10'd1;
      end
      // r_wrap marks the first clk at (0,0); the tick follows it by one clk
      r_wrap       <= r_pix_en && w_last_x && w_last_y;
      r_frame_tick <= r_wrap;
      r_hsync      <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync      <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_video_on   <= w_vid;
      r_cx         <= w_vid ? w_cx_full[5:0] : 6'd63;
      r_cy         <= w_vid ? w_cy_full[5:0] : 6'd63;
    end
  end

  assign pix_en     = r_pix_en;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign video_on   = r_video_on;
  assign counter_x  = r_cx;
  assign counter_y  = r_cy;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_cell_timing.sv
// Bench: default-size and shrunken-frame instances checked every clk
// against an arithmetic model indexed by clk edges since reset release.
module tb_vga_cell_timing;

  logic clk;
  logic rst;

  logic       a_pe, a_hs, a_vs, a_vo, a_tk;
  logic [9:0] a_x, a_y;
  logic [5:0] a_cx, a_cy;
  logic       b_pe, b_hs, b_vs, b_vo, b_tk;
  logic [9:0] b_x, b_y;
  logic [5:0] b_cx, b_cy;

  int n_checks = 0;
  int n_fails  = 0;
  int k        = 0;

  typedef struct {
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic [5:0] cx;
    logic [5:0] cy;
    logic       tk;
  } exp_t;

  vga_cell_timing dut_def (
    .clk(clk), .rst(rst), .pix_en(a_pe), .pix_x(a_x), .pix_y(a_y),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
    .counter_x(a_cx), .counter_y(a_cy), .frame_tick(a_tk)
  );

  vga_cell_timing #(
    .CLK_DIV(3), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CELL_SHIFT(2), .SYNC_POL(1'b1)
  ) dut_small (
    .clk(clk), .rst(rst), .pix_en(b_pe), .pix_x(b_x), .pix_y(b_y),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
    .counter_x(b_cx), .counter_y(b_cy), .frame_tick(b_tk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after k clk edges since reset release.
  function automatic exp_t model(int kk, int d, int ha, int hfp, int hs,
                                 int hbp, int va, int vfp, int vs, int vbp,
                                 int cs, bit pol);
    exp_t e;
    int ht, vt, p, p1, p2, x1, y1;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    if (kk == 0) begin
      e.pe = 0; e.x = 0; e.y = 0;
      e.hs = !pol; e.vs = !pol; e.vo = 0;
      e.cx = 63; e.cy = 63; e.tk = 0;
      return e;
    end
    p  = kk / d;
    p1 = (kk - 1) / d;
    p2 = (kk >= 2) ? (kk - 2) / d : 0;
    e.pe = ((kk + 1) % d) == 0;
    e.x  = 10'(p % ht);
    e.y  = 10'((p / ht) % vt);
    x1 = p1 % ht;
    y1 = (p1 / ht) % vt;
    e.vo = (x1 < ha) && (y1 < va);
    e.hs = (x1 >= ha + hfp && x1 < ha + hfp + hs) ? pol : !pol;
    e.vs = (y1 >= va + vfp && y1 < va + vfp + vs) ? pol : !pol;
    e.cx = e.vo ? 6'((x1 >> cs) & 63) : 6'd63;
    e.cy = e.vo ? 6'((y1 >> cs) & 63) : 6'd63;
    e.tk = (p1 > 0) && (p1 % (ht * vt) == 0) && (p1 != p2);
    return e;
  endfunction

  function automatic exp_t model_def(int kk);
    return model(kk, 4, 640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0);
  endfunction

  function automatic exp_t model_small(int kk);
    return model(kk, 3, 40, 4, 6, 6, 20, 2, 2, 3, 2, 1'b1);
  endfunction

  task automatic chk(string tag, int obs, int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, expv);
    end
  endtask

  task automatic check_all();
    exp_t ea, eb;
    ea = model_def(k);
    eb = model_small(k);
    chk("def.pix_en", int'(a_pe), int'(ea.pe));
    chk("def.pix_x", int'(a_x), int'(ea.x));
    chk("def.pix_y", int'(a_y), int'(ea.y));
    chk("def.hsync", int'(a_hs), int'(ea.hs));
    chk("def.vsync", int'(a_vs), int'(ea.vs));
    chk("def.video_on", int'(a_vo), int'(ea.vo));
    chk("def.counter_x", int'(a_cx), int'(ea.cx));
    chk("def.counter_y", int'(a_cy), int'(ea.cy));
    chk("def.frame_tick", int'(a_tk), int'(ea.tk));
    chk("sml.pix_en", int'(b_pe), int'(eb.pe));
    chk("sml.pix_x", int'(b_x), int'(eb.x));
    chk("sml.pix_y", int'(b_y), int'(eb.y));
    chk("sml.hsync", int'(b_hs), int'(eb.hs));
    chk("sml.vsync", int'(b_vs), int'(eb.vs));
    chk("sml.video_on", int'(b_vo), int'(eb.vo));
    chk("sml.counter_x", int'(b_cx), int'(eb.cx));
    chk("sml.counter_y", int'(b_cy), int'(eb.cy));
    chk("sml.frame_tick", int'(b_tk), int'(eb.tk));
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_all();
    end
  endtask

  // Drop reset between edges, check without any clk edge, then hold.
  task automatic async_rst(int hold);
    @(posedge clk);
    #2 rst = 1'b0;
    k = 0;
    #1 check_all();
    repeat (hold) begin
      @(negedge clk);
      check_all();
    end
    rst = 1'b1;
  endtask

  initial begin
    int budget;
    exp_t eb;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_all();
    end
    rst = 1'b1;

    run(10000);

    budget = 5000;
    eb = model_small(k);
    while (!(eb.x == 10'd30 && eb.y == 10'd10) && budget > 0) begin
      run(1);
      eb = model_small(k);
      budget--;
    end
    n_checks++;
    assert (budget > 0) else begin
      n_fails++;
      $error("FAIL wait_mid_line observed=timeout expected=pix(30,10)");
    end
    async_rst(3);
    run(4700);

    repeat (3) begin
      run($urandom_range(200, 3000));
      async_rst($urandom_range(1, 6));
      run($urandom_range(50, 400));
    end

    run(5000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
